sdram_rv_initiator: RTL and testbench
=====================================

Name: sdram_rv_initiator

Overview:
- Initiator-side bridge between the IOSys RISC-V 32-bit memory bus (valid/ready, byte strobes) and the SDRAM controller's RV port.
- The SDRAM RV port is a 16-bit half-word port with a toggle req/ack handshake.
- Each 32-bit CPU access is split into one or two half-word transfers. For reads, the two halves are reassembled into one 32-bit word.
- A timeout watchdog detects a lost acknowledge, and the bridge resynchronises to the toggle channel afterwards.

Parameters:
- ADDR_WIDTH, 23, width of the CPU/RV byte address.
- TIMEOUT_CYCLES, 1024, maximum cycles spent waiting for one ack before forced completion; must be ≥2.

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  asynchronous, active-high reset
- i_mem_valid  input  1  CPU request valid; held until o_mem_ready
- o_mem_ready  output  1  one-cycle completion pulse
- i_mem_addr  input  ADDR_WIDTH  CPU byte address; bits [1:0] ignored
- i_mem_wdata  input  32  write data
- i_mem_wstrb  input  4  byte strobes; 0 = read
- o_mem_rdata  output  32  read data; valid while o_mem_ready=1
- o_rv_addr  output  ADDR_WIDTH  latched address to SDRAM port
- o_rv_word  output  1  half select: 0 = bits[15:0], 1 = bits[31:16]
- o_rv_wdata  output  32  latched write data
- o_rv_ds  output  2  byte enables of current half
- o_rv_wstrb  output  4  latched strobes (port derives we = wstrb≠0)
- o_rv_req  output  1  request toggle
- i_rv_req_ack  input  1  ack toggle; transfer complete when equal to o_rv_req
- i_rv_dout  input  16  half-word read data, valid when ack matches
- o_timeout  output  1  sticky flag: an ack timeout occurred

Behaviour:
- Reset values:
  - o_mem_ready = 0, o_mem_rdata = 0, o_rv_req = 0, o_rv_word = 0, o_rv_ds = 0, o_rv_addr/wdata/wstrb = 0, o_timeout = 0.
  - FSM = IDLE, wait counter = 0.
  - Reset mid-operation abandons the transfer immediately. The SDRAM controller is reset by the same event.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - When i_mem_valid=1 and o_mem_ready=0, latch addr/wdata/wstrb and compute the pending-half mask.
  - Read: both halves. Write: low half if wstrb[1:0]≠0, high half if wstrb[3:2]≠0.
  - First half = lowest pending half. Go to ISSUE.
- ISSUE:
  - Drive o_rv_word with the current half.
  - o_rv_ds: read = 2'b11; write = wstrb[1:0] for the low half, wstrb[3:2] for the high half.
  - If i_rv_req_ack ≠ o_rv_req (channel still busy from a timed-out transfer), stall in ISSUE.
  - Otherwise toggle o_rv_req at this edge, clear the counter, and go to WAIT.
- WAIT:
  - When i_rv_req_ack == o_rv_req:
    - On a read, capture i_rv_dout into o_mem_rdata[15:0] or o_mem_rdata[31:16].
    - Clear that half's pending bit. If another half is pending, go to ISSUE; else go to DONE.
  - Else increment the counter. At TIMEOUT_CYCLES-1, set o_timeout, clear the pending mask, and go to DONE. Uncaptured read halves return 16'h0000.
- DONE: o_mem_ready = 1 for exactly one cycle, then go to IDLE.
  - IDLE ignores i_mem_valid during the ready cycle, so a held valid is never re-accepted.
- o_rv_addr, o_rv_wdata and o_rv_wstrb are stable from ISSUE through the end of WAIT.
- o_mem_rdata is cleared when a new read is accepted and holds until the next acceptance.
- Latency with the ack arriving K cycles after the toggle:
  - Single half (write): ready 3+K cycles after accept.
  - Two halves: ready 5+2K cycles after accept.
- Simultaneous ack and timeout terminal count: the ack wins and o_timeout is not set.
- o_timeout clears only on reset.

Test Plan:
- Read @0x066000, responder returns 16'h1234 then 16'hABCD, K=2 → two toggles, o_rv_word 0 then 1, ds=2'b11, o_mem_rdata=32'hABCD1234, ready high 9 cycles after accept.
- Write wstrb=4'b0011 data 32'hDEADBEEF → exactly one toggle, o_rv_word=0, ds=2'b11, o_rv_wstrb=4'b0011, ready 5 cycles after accept.
- Write wstrb=4'b0100 → one toggle only, o_rv_word=1, ds=2'b01, no low-half transfer.
- Responder never acks, TIMEOUT_CYCLES=16 → ready after timeout with rdata=0, o_timeout=1.
  - Next request stalls in ISSUE until a late ack arrives, then proceeds normally.
- Back-to-back reads with valid held one cycle after ready → no duplicate transfer; second request accepted only after the valid re-assertion.
- Assert i_reset in WAIT of a two-half read → all outputs return to reset values asynchronously; after release, the next read completes with correct data.

Source files
------------

// File: rtl/sdram_rv_initiator_if.sv
// rtl/sdram_rv_initiator_if.sv - CPU memory bus and SDRAM RV half-word port bundle
interface sdram_rv_initiator_if #(
    parameter int ADDR_WIDTH = 23
);
    // CPU side (valid/ready with byte strobes)
    logic                  i_mem_valid;
    logic                  o_mem_ready;
    logic [ADDR_WIDTH-1:0] i_mem_addr;
    logic [31:0]           i_mem_wdata;
    logic [3:0]            i_mem_wstrb;
    logic [31:0]           o_mem_rdata;

    // SDRAM RV side (toggle req/ack, 16-bit halves)
    logic [ADDR_WIDTH-1:0] o_rv_addr;
    logic                  o_rv_word;
    logic [31:0]           o_rv_wdata;
    logic [1:0]            o_rv_ds;
    logic [3:0]            o_rv_wstrb;
    logic                  o_rv_req;
    logic                  i_rv_req_ack;
    logic [15:0]           i_rv_dout;

    logic                  o_timeout;

    // Bridge view
    modport master (
        input  i_mem_valid, i_mem_addr, i_mem_wdata, i_mem_wstrb,
        output o_mem_ready, o_mem_rdata,
        output o_rv_addr, o_rv_word, o_rv_wdata, o_rv_ds, o_rv_wstrb, o_rv_req,
        input  i_rv_req_ack, i_rv_dout,
        output o_timeout
    );

    // CPU plus SDRAM controller view
    modport slave (
        output i_mem_valid, i_mem_addr, i_mem_wdata, i_mem_wstrb,
        input  o_mem_ready, o_mem_rdata,
        input  o_rv_addr, o_rv_word, o_rv_wdata, o_rv_ds, o_rv_wstrb, o_rv_req,
        output i_rv_req_ack, i_rv_dout,
        input  o_timeout
    );
endinterface

// File: rtl/sdram_rv_initiator.sv
// rtl/sdram_rv_initiator.sv - 32-bit CPU bus to 16-bit toggle-handshake SDRAM RV port bridge
module sdram_rv_initiator #(
    parameter int ADDR_WIDTH     = 23,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    sdram_rv_initiator_if.master bus
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    logic [1:0]            pending;
    logic [CW-1:0]         wait_cnt;
    logic                  mem_ready;
    logic [31:0]           mem_rdata;
    logic [ADDR_WIDTH-1:0] rv_addr;
    logic                  rv_word;
    logic [31:0]           rv_wdata;
    logic [1:0]            rv_ds;
    logic [3:0]            rv_wstrb;
    logic                  rv_req;
    logic                  timeout;

    logic [1:0]            accept_pend;
    logic                  accept_half;
    logic [1:0]            remaining;
    logic                  ack_match;
    logic                  is_read;

    // Byte enables for one half: reads fetch both bytes, writes use that half's strobes
    function automatic logic [1:0] half_ds(input logic half, input logic [3:0] strobes);
        if (strobes == 4'b0000)
            return 2'b11;
        return half ? strobes[3:2] : strobes[1:0];
    endfunction

    // Halves needed by the incoming request and which of them goes first
    assign accept_pend = (bus.i_mem_wstrb == 4'b0000) ? 2'b11
                       : {|bus.i_mem_wstrb[3:2], |bus.i_mem_wstrb[1:0]};
    assign accept_half = ~accept_pend[0];
    assign remaining   = pending & ~(rv_word ? 2'b10 : 2'b01);
    assign ack_match   = (bus.i_rv_req_ack == rv_req);
    assign is_read     = (rv_wstrb == 4'b0000);

    // Transfer sequencer: accept, issue each half, wait for ack or timeout, pulse ready
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= IDLE;
            pending   <= 2'b00;
            wait_cnt  <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= 32'h0;
            rv_addr   <= '0;
            rv_word   <= 1'b0;
            rv_wdata  <= 32'h0;
            rv_ds     <= 2'b00;
            rv_wstrb  <= 4'b0000;
            rv_req    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mem_ready <= 1'b0;
                    // Ready still high means the held valid belongs to the request just finished
                    if (bus.i_mem_valid && !mem_ready) begin
                        rv_addr  <= bus.i_mem_addr;
                        rv_wdata <= bus.i_mem_wdata;
                        rv_wstrb <= bus.i_mem_wstrb;
                        pending  <= accept_pend;
                        rv_word  <= accept_half;
                        rv_ds    <= half_ds(accept_half, bus.i_mem_wstrb);
                        if (bus.i_mem_wstrb == 4'b0000)
                            mem_rdata <= 32'h0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A mismatch here is a late ack from an abandoned transfer; let it drain
                    if (ack_match) begin
                        rv_req   <= ~rv_req;
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (ack_match) begin
                        if (is_read) begin
                            if (rv_word)
                                mem_rdata[31:16] <= bus.i_rv_dout;
                            else
                                mem_rdata[15:0] <= bus.i_rv_dout;
                        end
                        pending <= remaining;
                        if (|remaining) begin
                            // Only the high half can still be outstanding after the low one
                            rv_word <= 1'b1;
                            rv_ds   <= half_ds(1'b1, rv_wstrb);
                            state   <= ISSUE;
                        end else begin
                            state <= DONE;
                        end
                    end else if (wait_cnt == CNT_LAST) begin
                        timeout <= 1'b1;
                        pending <= 2'b00;
                        state   <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    mem_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_mem_ready = mem_ready;
    assign bus.o_mem_rdata = mem_rdata;
    assign bus.o_rv_addr   = rv_addr;
    assign bus.o_rv_word   = rv_word;
    assign bus.o_rv_wdata  = rv_wdata;
    assign bus.o_rv_ds     = rv_ds;
    assign bus.o_rv_wstrb  = rv_wstrb;
    assign bus.o_rv_req    = rv_req;
    assign bus.o_timeout   = timeout;

endmodule

// File: tb/tb_sdram_rv_initiator.sv
// tb/tb_sdram_rv_initiator.sv - self-checking bench for sdram_rv_initiator
module tb_sdram_rv_initiator;

    localparam int AW = 23;
    localparam int T  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_rv_initiator_if #(.ADDR_WIDTH(AW)) bus();

    sdram_rv_initiator #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct {
        logic          word;
        logic [1:0]    ds;
        logic [3:0]    wstrb;
        logic [AW-1:0] addr;
    } xfer_t;

    int          ncmp = 0;
    int          nmis = 0;
    int          cyc = 0;
    int          toggles = 0;
    int          c0 = 0;
    int          lat = 0;
    logic [31:0] rdv;
    xfer_t       log[$];
    logic [15:0] rmem[int];
    logic [31:0] ref_mem[int];

    // SDRAM responder state
    bit            resp_en = 1'b1;
    int            resp_k = 2;
    logic          seen_req;
    int            rcnt;
    logic          p_we;
    logic          p_word;
    logic [1:0]    p_ds;
    logic [AW-1:0] p_addr;
    logic [31:0]   p_wdata;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int hkey(input logic [AW-1:0] a, input logic w);
        return int'({a[AW-1:2], w});
    endfunction

    function automatic logic [15:0] mem_read(input int key);
        return rmem.exists(key) ? rmem[key] : 16'h0000;
    endfunction

    task automatic mem_write(input int key, input logic [1:0] ds, input logic [15:0] d);
        logic [15:0] old;
        old = mem_read(key);
        if (ds[0]) old[7:0]  = d[7:0];
        if (ds[1]) old[15:8] = d[15:8];
        rmem[key] = old;
    endtask

    // Half-word SDRAM model: latches each request when it sees the toggle, acks K cycles after it
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.i_rv_req_ack <= 1'b0;
            bus.i_rv_dout    <= 16'h0;
            seen_req         <= 1'b0;
            rcnt             <= 0;
        end else if (bus.o_rv_req != seen_req) begin
            seen_req <= bus.o_rv_req;
            p_we     <= (bus.o_rv_wstrb != 4'b0000);
            p_word   <= bus.o_rv_word;
            p_ds     <= bus.o_rv_ds;
            p_addr   <= bus.o_rv_addr;
            p_wdata  <= bus.o_rv_wdata;
            rcnt     <= 1;
            toggles  <= toggles + 1;
            log.push_back('{bus.o_rv_word, bus.o_rv_ds, bus.o_rv_wstrb, bus.o_rv_addr});
        end else if (seen_req != bus.i_rv_req_ack) begin
            if (resp_en && (rcnt + 1 >= resp_k)) begin
                bus.i_rv_req_ack <= seen_req;
                if (p_we)
                    mem_write(hkey(p_addr, p_word), p_ds, p_word ? p_wdata[31:16] : p_wdata[15:0]);
                else
                    bus.i_rv_dout <= mem_read(hkey(p_addr, p_word));
            end else begin
                rcnt <= rcnt + 1;
            end
        end
    end

    // Word-level reference memory
    function automatic logic [31:0] ref_read(input logic [AW-1:0] a);
        int k = int'(a[AW-1:2]);
        return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    endfunction

    task automatic ref_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = ref_read(a);
        for (int b = 0; b < 4; b++)
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[int'(a[AW-1:2])] = w;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        ref_mem[int'(a[AW-1:2])] = d;
        rmem[hkey(a, 1'b0)] = d[15:0];
        rmem[hkey(a, 1'b1)] = d[31:16];
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] ws);
        @(negedge clk);
        bus.i_mem_valid = 1'b1;
        bus.i_mem_addr  = a;
        bus.i_mem_wdata = wd;
        bus.i_mem_wstrb = ws;
        c0 = cyc + 1;
    endtask

    task automatic wait_ready(input bit hold);
        bit ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (bus.o_mem_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("ready_seen", 64'(ok), 64'd1);
        lat = cyc - c0;
        rdv = bus.o_mem_rdata;
        if (hold) @(negedge clk);
        bus.i_mem_valid = 1'b0;
    endtask

    // One complete CPU access with latency, transfer sequence and data checks
    task automatic do_tx(input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         input int k, input string tag);
        int    t0;
        int    nh;
        xfer_t expq[$];
        resp_k = k;
        t0 = toggles;
        log.delete();
        if (ws == 4'b0000) begin
            expq.push_back('{1'b0, 2'b11, ws, a});
            expq.push_back('{1'b1, 2'b11, ws, a});
        end else begin
            if (ws[1:0] != 2'b00) expq.push_back('{1'b0, ws[1:0], ws, a});
            if (ws[3:2] != 2'b00) expq.push_back('{1'b1, ws[3:2], ws, a});
        end
        nh = expq.size();
        drive(a, wd, ws);
        wait_ready(1'b0);
        chk({tag, " latency"}, 64'(lat), 64'((nh == 2) ? 5 + 2 * k : 3 + k));
        chk({tag, " toggles"}, 64'(toggles - t0), 64'(nh));
        for (int i = 0; i < nh && i < log.size(); i++) begin
            chk({tag, " word"},  64'(log[i].word),  64'(expq[i].word));
            chk({tag, " ds"},    64'(log[i].ds),    64'(expq[i].ds));
            chk({tag, " wstrb"}, 64'(log[i].wstrb), 64'(expq[i].wstrb));
            chk({tag, " addr"},  64'(log[i].addr),  64'(expq[i].addr));
        end
        if (ws == 4'b0000)
            chk({tag, " rdata"}, 64'(rdv), 64'(ref_read(a)));
        else
            ref_write(a, wd, ws);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " ready"},   64'(bus.o_mem_ready), 64'd0);
        chk({tag, " rdata"},   64'(bus.o_mem_rdata), 64'd0);
        chk({tag, " req"},     64'(bus.o_rv_req),    64'd0);
        chk({tag, " word"},    64'(bus.o_rv_word),   64'd0);
        chk({tag, " ds"},      64'(bus.o_rv_ds),     64'd0);
        chk({tag, " addr"},    64'(bus.o_rv_addr),   64'd0);
        chk({tag, " wdata"},   64'(bus.o_rv_wdata),  64'd0);
        chk({tag, " wstrb"},   64'(bus.o_rv_wstrb),  64'd0);
        chk({tag, " timeout"}, 64'(bus.o_timeout),   64'd0);
    endtask

    initial begin
        int            t0;
        bit            hit;
        logic [AW-1:0] ra;
        logic [3:0]    rs;

        bus.i_mem_valid = 1'b0;
        bus.i_mem_addr  = '0;
        bus.i_mem_wdata = 32'h0;
        bus.i_mem_wstrb = 4'h0;
        preload(23'h066000, 32'hABCD1234);
        preload(23'h066100, 32'h55AA7E81);

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed accesses
        do_tx(23'h066000, 32'h0, 4'b0000, 2, "read_two_halves");
        chk("read_two_halves value", 64'(rdv), 64'hABCD1234);
        do_tx(23'h066008, 32'hDEADBEEF, 4'b0011, 2, "write_low");
        do_tx(23'h06600C, 32'h13572468, 4'b0100, 2, "write_high_only");
        do_tx(23'h066008, 32'h0, 4'b0000, 3, "readback_low");
        chk("readback_low value", 64'(rdv), 64'h0000BEEF);

        // Randomized accesses over a small window so reads hit earlier writes
        for (int i = 0; i < 24; i++) begin
            ra = 23'h066000 + AW'($urandom_range(0, 7) << 2);
            rs = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            do_tx(ra, $urandom, rs, int'($urandom_range(2, 5)), "random");
        end

        // Ack landing on the terminal count beats the timeout
        do_tx(23'h066000, 32'h0, 4'b0000, T - 1, "ack_at_terminal");
        chk("ack_at_terminal timeout", 64'(bus.o_timeout), 64'd0);

        // Lost ack: forced completion after the watchdog expires
        resp_en = 1'b0;
        t0 = toggles;
        drive(23'h066100, 32'h0, 4'b0000);
        wait_ready(1'b0);
        chk("timeout latency", 64'(lat), 64'(2 + T));
        chk("timeout rdata", 64'(rdv), 64'd0);
        chk("timeout flag", 64'(bus.o_timeout), 64'd1);
        chk("timeout toggles", 64'(toggles - t0), 64'd1);

        // Next request must not toggle until the stale ack drains
        t0 = toggles;
        drive(23'h066010, 32'hCAFEF00D, 4'b1111);
        repeat (8) @(negedge clk);
        chk("stall toggles", 64'(toggles - t0), 64'd0);
        chk("stall ready", 64'(bus.o_mem_ready), 64'd0);
        resp_k  = 2;
        resp_en = 1'b1;
        wait_ready(1'b0);
        chk("stall done toggles", 64'(toggles - t0), 64'd2);
        chk("stall timeout sticky", 64'(bus.o_timeout), 64'd1);
        ref_write(23'h066010, 32'hCAFEF00D, 4'b1111);
        do_tx(23'h066010, 32'h0, 4'b0000, 3, "after_stall");
        chk("after_stall value", 64'(rdv), 64'hCAFEF00D);

        // Valid held one cycle past ready is not re-accepted
        resp_k = 2;
        t0 = toggles;
        drive(23'h066100, 32'h0, 4'b0000);
        wait_ready(1'b1);
        chk("b2b first rdata", 64'(rdv), 64'h55AA7E81);
        repeat (6) @(negedge clk);
        chk("b2b no duplicate", 64'(toggles - t0), 64'd2);
        chk("b2b idle ready", 64'(bus.o_mem_ready), 64'd0);
        do_tx(23'h066010, 32'h0, 4'b0000, 2, "b2b second");

        // Asynchronous reset during the second half's wait
        resp_k = 4;
        t0 = toggles;
        drive(23'h066100, 32'h0, 4'b0000);
        hit = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (toggles - t0 == 2) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reset_mid reached", 64'(hit), 64'd1);
        chk("reset_mid partial rdata", 64'(bus.o_mem_rdata), 64'h00007E81);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("reset_mid");
        bus.i_mem_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_tx(23'h066100, 32'h0, 4'b0000, 2, "after_reset");
        chk("after_reset value", 64'(rdv), 64'h55AA7E81);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
        $finish;
    end

endmodule
